ram_responder: RTL
==================

# ram_responder

Memory-side responder for the single-port RAM request interface driven by the instruction/data request arbiter. It accepts one word read (`Ren`) or write (`Wen`) at a time on `ramaddr`/`ramstore` and completes it after a fixed, parameterised wait. While the access is in progress it holds `busy_o` high. It returns read data on `ramload`. It serves as both the synthesizable on-chip RAM and the latency model used by the CPU benches.

## Interface
Parameters:
- `LATENCY`, default 2: number of wait cycles between acceptance and completion; legal range 0..15.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.

Ports:
- `CLK` input 1: clock; all state updates on the rising edge.
- `nRST` input 1: asynchronous, active-low reset.
- `Ren` input 1: read request, level-held by the requester.
- `Wen` input 1: write request, level-held by the requester.
- `ramaddr` input 32: byte address. Word index is `ramaddr[$clog2(DEPTH_WORDS)+1:2]`; bits [1:0] and the upper bits are ignored, so addresses wrap modulo the depth.
- `ramstore` input 32: write data.
- `ramload` output 32: read data; registered.
- `busy_o` output 1: high while an accepted request is not yet complete.

## Operation
- FSM states are IDLE, WAIT and DONE.
- **IDLE**
  - `busy_o = Ren | Wen` (combinational).
  - If a request is present on the rising edge: latch the word index, `ramstore` and the op into registers.
  - Op is write if `Wen`, else read. `Wen` has priority when both are high.
  - Load the counter with `LATENCY`. Go to WAIT if `LATENCY > 0`, else commit the access and go directly to DONE.
- **WAIT**
  - `busy_o = 1`. Decrement the counter each cycle.
  - When the counter equals 1, commit the access and go to DONE.
  - If both `Ren` and `Wen` are low on the edge, abort: return to IDLE with no memory write and no `ramload` change.
- **Commit**
  - Read: `ramload <= mem[latched index]`.
  - Write: `mem[latched index] <= latched data`; `ramload` is unchanged.
- **DONE**
  - `busy_o = 0` for exactly one cycle; `ramload` is valid in this cycle for reads.
  - Go to IDLE unconditionally on the next edge.
- Changes to the inputs after acceptance are ignored because address, data and op are latched.
- A request still held in IDLE after DONE is treated as a new access. The requester must switch or deassert it on seeing `busy_o` low.
- Read-after-write to the same address in consecutive accesses returns the new data.

## Timing
- Reset values:
  - state = IDLE, counter = 0, `ramload` = 32'h0.
  - `busy_o` follows `Ren | Wen` combinationally, so it is 0 whenever no request is present.
  - Memory contents are not cleared by reset.
- Latency: a request first seen on edge t0 ends with `busy_o` low during cycle t0+LATENCY+1.
  - LATENCY=2: busy high for cycles 0–2, low in cycle 3.
  - LATENCY=0: busy high in cycle 0, low in cycle 1.
- Throughput: one access per LATENCY+2 cycles with back-to-back requests (IDLE costs one cycle).
- Reset asserted mid-WAIT: return to IDLE immediately. No write occurs and `ramload` is cleared to 0.
- Abort in WAIT takes effect on the edge where the request is seen low. The abort is not visible in `busy_o` until IDLE.
- Counter width: `$clog2(LATENCY+1)`, with a minimum of 1 bit.

## Structure
- `ram_pkg` contains:
  - `ramstate_t` (IDLE, WAIT, DONE);
  - `RAM_WORD_W = 32`;
  - the `ramop_t` enum (RD, WR).
- Sub-module `ram_array` provides:
  - the storage array: synchronous write with a write-enable;
  - a synchronous read port with a read-enable that loads `ramload`;
  - no reset on the storage.
- `ram_responder` holds the FSM, counter, request latches and `busy_o` logic.

## Test plan
All scenarios use LATENCY=2 and DEPTH_WORDS=1024.
- Reset, then idle: `nRST=0`, no request → `busy_o=0`, `ramload=0`. Release with `Ren=Wen=0` → state stays IDLE and `busy_o` stays 0.
- Write then read:
  - `Wen=1`, `ramaddr=32'h56785678`, `ramstore=32'h43214321` → `busy_o` high for 3 cycles, then low for 1 cycle.
  - Then `Ren=1` at the same address → `ramload=32'h43214321` in the DONE cycle.
- Input change after acceptance: `Wen=1`, `ramaddr=32'h00000010`, `ramstore=32'h11111111`. One cycle later change `ramaddr` to 32'h20 and `ramstore` to 32'h22222222. A read of 32'h10 must return 32'h11111111, and a read of 32'h20 must return the old value.
- Priority and wrap: `Ren=Wen=1` at `ramaddr=32'h00001004` with `ramstore=32'hABCDABCD` → write occurs. A read of 32'h00000004 returns 32'hABCDABCD.
- Abort and reset: `Wen=1` to 32'h30 with 32'h33333333, dropped after one WAIT cycle → no write; a read returns the prior value. Then start a read and pulse `nRST` low mid-WAIT → `busy_o` follows the request and `ramload=0`. After release, the FSM serves a new access normally.
- LATENCY=0 build: a read is accepted at t0, `busy_o` goes low at t0+1 with valid data. Back-to-back reads complete every 2 cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM responder and its storage array.
package ram_pkg;

  localparam int RAM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ramstate_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } ramop_t;

endpackage

// File: rtl/ram_array.sv
// Word storage with a synchronous write port and a registered, enabled read port.
module ram_array
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [AW-1:0]         addr,
  input  logic [RAM_WORD_W-1:0] wdata,
  output logic [RAM_WORD_W-1:0] rdata
);

  logic [RAM_WORD_W-1:0] mem [DEPTH_WORDS];

  // Storage is deliberately left out of reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Single-port RAM responder: accepts one read or write, holds busy_o for a
// fixed latency, then commits the access and reports completion for one cycle.
module ram_responder
  import ram_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  Ren,
  input  logic                  Wen,
  input  logic [31:0]           ramaddr,
  input  logic [RAM_WORD_W-1:0] ramstore,
  output logic [RAM_WORD_W-1:0] ramload,
  output logic                  busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  ramstate_t             state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [AW-1:0]         idx_q;
  logic [RAM_WORD_W-1:0] data_q;
  ramop_t                op_q;
  logic                  latch;

  logic                  mem_wr, mem_rd;
  logic [AW-1:0]         mem_addr;
  logic [RAM_WORD_W-1:0] mem_wdata;

  logic [AW-1:0]         req_idx;
  logic                  unused_addr_bits;

  assign req_idx          = ramaddr[AW+1:2];
  assign unused_addr_bits = ^{ramaddr[31:AW+2], ramaddr[1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      data_q <= '0;
      op_q   <= RD;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        idx_q  <= req_idx;
        data_q <= ramstore;
        op_q   <= Wen ? WR : RD;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    busy_o    = 1'b0;
    latch     = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = idx_q;
    mem_wdata = data_q;
    unique case (state)
      IDLE: begin
        busy_o = Ren | Wen;
        if (Ren || Wen) begin
          latch = 1'b1;
          cnt_n = LAT_C;
          if (LATENCY > 0) begin
            state_n = WAIT;
          end else begin
            // Zero latency commits straight from the live inputs.
            mem_addr  = req_idx;
            mem_wdata = ramstore;
            mem_wr    = Wen;
            mem_rd    = ~Wen;
            state_n   = DONE;
          end
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        // A dropped request wins over a commit falling on the same edge.
        if (!Ren && !Wen) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - ONE_C;
          if (cnt == ONE_C) begin
            mem_wr  = (op_q == WR);
            mem_rd  = (op_q == RD);
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (CLK),
    .rst_n(nRST),
    .wr_en(mem_wr),
    .rd_en(mem_rd),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(ramload)
  );

endmodule
